// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared FSM state type and default screen/colour constants for sprite_drawer
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    localparam int          DEF_SCREEN_W    = 640;
    localparam int          DEF_SCREEN_H    = 480;
    localparam logic [15:0] DEF_TRANSPARENT = 16'hF81F;

endpackage

// File: rtl/sprite_drawer.sv
// rtl/sprite_drawer.sv - sprite blitter from external ROM to framebuffer pixel stream
// Horizontal mirroring is built only when SPRITE_DRAWER_FLIP_EN is defined.
module sprite_drawer
    import sprite_pkg::*;
#(
    parameter int          SCREEN_W    = DEF_SCREEN_W,
    parameter int          SCREEN_H    = DEF_SCREEN_H,
    parameter logic [15:0] TRANSPARENT = DEF_TRANSPARENT
) (
    input  logic        sram_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    input  logic [5:0]  req_w,
    input  logic [5:0]  req_h,
    input  logic [15:0] req_base,
    input  logic        req_flip,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [9:0]  program_x,
    output logic [9:0]  program_y,
    output logic [15:0] program_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  w_q, w_d, h_q, h_d;
    logic [5:0]  col_q, col_d, row_q, row_d;
    logic [15:0] row_base_q, row_base_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [15:0] data_q, data_d;

    logic [5:0]  col_off;
    logic [15:0] addr_calc;
    logic [10:0] px, py;
    logic        skip, last_col, last_px;

`ifdef SPRITE_DRAWER_FLIP_EN
    logic flip_q, flip_d;
    assign col_off = flip_q ? (w_q - 6'd1 - col_q) : col_q;
`else
    logic unused_flip;
    assign unused_flip = req_flip;
    assign col_off     = col_q;
`endif

    assign addr_calc = row_base_q + {10'd0, col_off};
    // 11-bit sums so sprites hanging past the right/bottom edge clip instead of wrapping
    assign px        = {1'b0, x_q} + {5'd0, col_q};
    assign py        = {1'b0, y_q} + {5'd0, row_q};
    assign skip      = (px >= 11'(SCREEN_W)) || (py >= 11'(SCREEN_H)) || (data_q == TRANSPARENT);
    assign last_col  = (col_q == w_q - 6'd1);
    assign last_px   = last_col && (row_q == h_q - 6'd1);

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            data_q     <= '0;
`ifdef SPRITE_DRAWER_FLIP_EN
            flip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
`ifdef SPRITE_DRAWER_FLIP_EN
            flip_q     <= flip_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
`ifdef SPRITE_DRAWER_FLIP_EN
        flip_d     = flip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    x_d        = req_x;
                    y_d        = req_y;
                    w_d        = req_w;
                    h_d        = req_h;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = req_base;
`ifdef SPRITE_DRAWER_FLIP_EN
                    flip_d     = req_flip;
`endif
                    // an empty sprite is accepted and dropped without leaving IDLE
                    if (req_w != 6'd0 && req_h != 6'd0)
                        state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                rom_addr_d = addr_calc;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                data_d  = rom_data;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (skip || pix_ready) begin
                    state_d = last_px ? ST_IDLE : ST_ADDR;
                    if (last_col) begin
                        col_d      = '0;
                        row_d      = row_q + 6'd1;
                        row_base_d = row_base_q + {10'd0, w_q};
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        rom_addr     = (state_q == ST_ADDR) ? addr_calc : rom_addr_q;
        pix_valid    = (state_q == ST_OUT) && !skip;
        program_x    = px[9:0];
        program_y    = py[9:0];
        program_data = data_q;
    end

endmodule

// File: tb/tb_sprite_drawer.sv
// tb/tb_sprite_drawer.sv - directed self-checking bench for sprite_drawer
module tb_sprite_drawer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_x = '0, req_y = '0;
    logic [5:0]  req_w = '0, req_h = '0;
    logic [15:0] req_base = '0;
    logic        req_flip = 1'b0;
    logic [15:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic [9:0]  program_x, program_y;
    logic [15:0] program_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;

    int passed = 0;
    int total  = 0;

    logic [9:0]  got_x[$];
    logic [9:0]  got_y[$];
    logic [15:0] got_d[$];
    logic [15:0] addr_log[$];
    logic [15:0] transparent_addr = 16'hFFFF;

    sprite_drawer dut (
        .sram_clk    (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_w       (req_w),
        .req_h       (req_h),
        .req_base    (req_base),
        .req_flip    (req_flip),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .program_x   (program_x),
        .program_y   (program_y),
        .program_data(program_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ROM model: word = address, except one address that returns the transparent colour
    always @(posedge clk)
        rom_data <= (rom_addr == transparent_addr) ? 16'hF81F : rom_addr;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            got_x.push_back(program_x);
            got_y.push_back(program_y);
            got_d.push_back(program_data);
        end
        if (busy && (addr_log.size() == 0 || addr_log[$] != rom_addr))
            addr_log.push_back(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic clear_logs();
        got_x.delete();
        got_y.delete();
        got_d.delete();
        addr_log.delete();
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [5:0] w,
                        input logic [5:0] h, input logic [15:0] base, input logic flip);
        @(negedge clk);
        req_x = x; req_y = y; req_w = w; req_h = h; req_base = base; req_flip = flip;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 500) begin
            @(negedge clk);
            if (busy) cycles++;
        end
        total++;
        if (busy) $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", cycles);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || rom_addr !== 16'h0 ||
            program_x !== 10'h0 || program_y !== 10'h0 || program_data !== 16'h0) begin
            $display("FAIL reset_outputs: busy=%b pix_valid=%b rom_addr=0x%0h px=%0d py=%0d pd=0x%0h, required all 0",
                     busy, pix_valid, rom_addr, program_x, program_y, program_data);
        end else passed++;
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("reset_req_ready", req_ready, 1);
    endtask

    task automatic test_basic();
        int c;
        clear_logs();
        send(10'd10, 10'd20, 6'd2, 6'd2, 16'h0100, 1'b0);
        wait_idle(c);
        chk("basic_count", got_x.size(), 4);
        if (got_x.size() == 4) begin
            chk("basic_p0", {got_x[0], got_y[0], got_d[0]}, {10'd10, 10'd20, 16'h0100});
            chk("basic_p1", {got_x[1], got_y[1], got_d[1]}, {10'd11, 10'd20, 16'h0101});
            chk("basic_p2", {got_x[2], got_y[2], got_d[2]}, {10'd10, 10'd21, 16'h0102});
            chk("basic_p3", {got_x[3], got_y[3], got_d[3]}, {10'd11, 10'd21, 16'h0103});
        end
        chk("basic_busy_cycles", c, 12);
    endtask

    task automatic test_right_edge();
        int c;
        clear_logs();
        send(10'd638, 10'd0, 6'd4, 6'd1, 16'h0200, 1'b0);
        wait_idle(c);
        chk("edge_count", got_x.size(), 2);
        if (got_x.size() == 2) begin
            chk("edge_p0", {got_x[0], got_d[0]}, {10'd638, 16'h0200});
            chk("edge_p1", {got_x[1], got_d[1]}, {10'd639, 16'h0201});
        end
        chk("edge_rom_reads", addr_log.size(), 4);
        chk("edge_busy_cycles", c, 12);
    endtask

    task automatic test_transparent();
        int c;
        clear_logs();
        transparent_addr = 16'h0301;
        send(10'd5, 10'd5, 6'd3, 6'd1, 16'h0300, 1'b0);
        wait_idle(c);
        transparent_addr = 16'hFFFF;
        chk("transp_count", got_x.size(), 2);
        if (got_x.size() == 2) begin
            chk("transp_p0", {got_x[0], got_y[0], got_d[0]}, {10'd5, 10'd5, 16'h0300});
            chk("transp_p1", {got_x[1], got_y[1], got_d[1]}, {10'd7, 10'd5, 16'h0302});
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        int bad = 0;
        clear_logs();
        pix_ready = 1'b0;
        send(10'd1, 10'd2, 6'd2, 6'd1, 16'h0400, 1'b0);
        while (!pix_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("stall_valid_seen", pix_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || program_x !== 10'd1 || program_y !== 10'd2 || program_data !== 16'h0400)
                bad++;
        end
        chk("stall_hold_errors", bad, 0);
        pix_ready = 1'b1;
        wait_idle(c);
        chk("stall_count", got_x.size(), 2);
        if (got_x.size() == 2) begin
            chk("stall_p0", {got_x[0], got_y[0], got_d[0]}, {10'd1, 10'd2, 16'h0400});
            chk("stall_p1", {got_x[1], got_y[1], got_d[1]}, {10'd2, 10'd2, 16'h0401});
        end
    endtask

    task automatic test_zero_size();
        clear_logs();
        send(10'd3, 10'd3, 6'd0, 6'd3, 16'h0500, 1'b0);
        chk("zero_req_ready", req_ready, 1);
        chk("zero_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("zero_pixels", got_x.size(), 0);
    endtask

    task automatic test_flip();
        int c;
        clear_logs();
        send(10'd0, 10'd0, 6'd3, 6'd1, 16'h0010, 1'b1);
        wait_idle(c);
        chk("flip_reads", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
`ifdef SPRITE_DRAWER_FLIP_EN
            chk("flip_addr_seq", {addr_log[0], addr_log[1], addr_log[2]}, {16'h12, 16'h11, 16'h10});
`else
            chk("flip_addr_seq", {addr_log[0], addr_log[1], addr_log[2]}, {16'h10, 16'h11, 16'h12});
`endif
        end
    endtask

    task automatic test_reset_mid_sprite();
        clear_logs();
        send(10'd0, 10'd0, 6'd4, 6'd4, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || rom_addr !== 16'h0) begin
            $display("FAIL mid_reset_outputs: busy=%b pix_valid=%b rom_addr=0x%0h, required 0/0/0",
                     busy, pix_valid, rom_addr);
        end else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        @(posedge clk);
        #1 chk("mid_req_ready", req_ready, 1);
        repeat (20) @(negedge clk);
        chk("mid_no_resume_pixels", got_x.size(), 0);
        chk("mid_busy_after", busy, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_right_edge();
        test_transparent();
        test_backpressure();
        test_zero_size();
        test_flip();
        test_reset_mid_sprite();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
